// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle MIPS core.
// Includes the fetch FSM states, PCSrc encodings and the opcodes the fetch path cares about.
package cpu_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetchState_t;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_J   = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the instruction held in the fetch stage.
// Handles sequential flow, j/jal, jr/jalr and taken beq.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [1:0]  PCSrc,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] jr_addr,
  output logic [31:0] next_pc
);

  logic [31:0] seqPc;
  logic [31:0] branchOffset;
  logic        unusedOpBits;

  assign seqPc        = pc + 32'd4;
  assign branchOffset = {{14{instr[15]}}, instr[15:0], 2'b00};
  // Opcode bits are decoded upstream; only the immediate fields matter here.
  assign unusedOpBits = ^instr[31:26];

  always_comb begin
    next_pc = seqPc;
    case (PCSrc)
      PCSRC_J:   next_pc = {seqPc[31:28], instr[25:0], 2'b00};
      PCSRC_JR:  next_pc = jr_addr & 32'hFFFF_FFFC;
      PCSRC_SEQ: if (Branch && Zero) next_pc = seqPc + branchOffset;
      default:   next_pc = seqPc;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and holds
// the instruction for the decoder until the pipeline advances.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  PCSrc,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] jr_addr,
  output logic [31:0] instr,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic [31:0] retire_count
);

  fetchState_t state;
  logic [31:0] pc;
  logic [31:0] instrHeld;
  logic        validHeld;
  logic        reqHeld;
  logic [31:0] retireCnt;
  logic [31:0] nextPc;

  next_pc_calc u_next_pc_calc (
    .pc      (pc),
    .instr   (instrHeld),
    .PCSrc   (PCSrc),
    .Branch  (Branch),
    .Zero    (Zero),
    .jr_addr (jr_addr),
    .next_pc (nextPc)
  );

  // reqHeld stays low for the first cycle after reset release, so an ack there is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      instrHeld <= 32'd0;
      validHeld <= 1'b0;
      reqHeld   <= 1'b0;
      retireCnt <= 32'd0;
    end else begin
      case (state)
        FETCH: begin
          if (reqHeld && imem_ack) begin
            instrHeld <= imem_rdata;
            validHeld <= 1'b1;
            reqHeld   <= 1'b0;
            state     <= ISSUE;
          end else begin
            reqHeld <= 1'b1;
          end
        end
        ISSUE: begin
          if (!stall) begin
            pc        <= nextPc;
            retireCnt <= retireCnt + 32'd1;
            validHeld <= 1'b0;
            reqHeld   <= 1'b1;
            state     <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign imem_req     = reqHeld;
  assign imem_addr    = pc;
  assign instr        = instrHeld;
  assign OpCode       = instrHeld[31:26];
  assign Funct        = instrHeld[5:0];
  assign pc_plus4     = pc + 32'd4;
  assign instr_valid  = validHeld;
  assign retire_count = retireCnt;

endmodule
